pipeline_hazard_ctrl: RTL and testbench

Central sequencer for the five-stage MIPS pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Gates pipeline advance through a run/step/halt state machine driven by the debug unit.
- Detects load-use hazards between the instruction in ID and the load in EX, and injects a bubble into ID/EX.
- Flushes IF/ID on a taken branch or jump resolved in ID.
- Exposes cycle and stall counters to the debug unit.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/hazard_detect.sv | 32 +++
 rtl/pipeline_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared types and constants for the pipeline sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam int NB_ADDR = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// hazard_detect : combinational load-use hazard between ID and a load in EX
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int NB_ADDR = pipeline_pkg::NB_ADDR
) (
  input  logic [NB_ADDR-1:0] i_id_rs_addr,
  input  logic [NB_ADDR-1:0] i_id_rt_addr,
  input  logic               i_id_uses_rt,
  input  logic [NB_ADDR-1:0] i_ex_rt_addr,
  input  logic               i_ex_MemRead,
  output logic               o_luh
);

  logic w_rs_match;
  logic w_rt_match;
  logic w_dst_live;

  // A load into $zero never produces a value worth waiting for.
  assign w_dst_live = (i_ex_rt_addr != NB_ADDR'(REG_ZERO));
  assign w_rs_match = (i_ex_rt_addr == i_id_rs_addr);
  assign w_rt_match = i_id_uses_rt & (i_ex_rt_addr == i_id_rt_addr);
  assign o_luh      = i_ex_MemRead & w_dst_live & (w_rs_match | w_rt_match);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : run/step/halt sequencer, stall/flush control, counters
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int NB_ADDR = pipeline_pkg::NB_ADDR,
  parameter int NB_CNT  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_halt_wb,
  input  logic [NB_ADDR-1:0] i_id_rs_addr,
  input  logic [NB_ADDR-1:0] i_id_rt_addr,
  input  logic               i_id_uses_rt,
  input  logic [NB_ADDR-1:0] i_ex_rt_addr,
  input  logic               i_ex_MemRead,
  input  logic               i_branch_taken,
  input  logic               i_jump,
  output logic               o_pc_en,
  output logic               o_if_id_en,
  output logic               o_if_id_flush,
  output logic               o_id_ex_en,
  output logic               o_id_ex_bubble,
  output logic               o_ex_mem_en,
  output logic               o_mem_wb_en,
  output logic [1:0]         o_state,
  output logic [NB_CNT-1:0]  o_cycle_cnt,
  output logic [NB_CNT-1:0]  o_stall_cnt
);

  state_e            state_q, state_d;
  logic [NB_CNT-1:0] cycle_q, cycle_d;
  logic [NB_CNT-1:0] stall_q, stall_d;
  logic              w_adv;
  logic              w_luh;

  hazard_detect #(
    .NB_ADDR (NB_ADDR)
  ) u_hazard_detect (
    .i_id_rs_addr (i_id_rs_addr),
    .i_id_rt_addr (i_id_rt_addr),
    .i_id_uses_rt (i_id_uses_rt),
    .i_ex_rt_addr (i_ex_rt_addr),
    .i_ex_MemRead (i_ex_MemRead),
    .o_luh        (w_luh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_adv   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_run)       state_d = RUN;
        else if (i_step) state_d = STEP;
      end
      RUN: begin
        w_adv = 1'b1;
        if (i_halt_wb)   state_d = HALTED;
        else if (!i_run) state_d = IDLE;
      end
      // A step is a single advance; a held i_step is not re-armed here.
      STEP: begin
        w_adv   = 1'b1;
        state_d = i_halt_wb ? HALTED : IDLE;
      end
      default: state_d = HALTED;
    endcase

    cycle_d = w_adv ? cycle_q + 1'b1 : cycle_q;
    stall_d = (w_adv & w_luh) ? stall_q + 1'b1 : stall_q;
  end

  // A stalled branch is re-evaluated next cycle, so the stall suppresses the flush.
  assign o_pc_en        = w_adv & ~w_luh;
  assign o_if_id_en     = w_adv & ~w_luh;
  assign o_if_id_flush  = w_adv & ~w_luh & (i_branch_taken | i_jump);
  assign o_id_ex_en     = w_adv;
  assign o_id_ex_bubble = w_adv & w_luh;
  assign o_ex_mem_en    = w_adv;
  assign o_mem_wb_en    = w_adv;
  assign o_state        = state_q;
  assign o_cycle_cnt    = cycle_q;
  assign o_stall_cnt    = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed and randomized checks against a cycle model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int NB_ADDR = 5;
  localparam int NB_CNT  = 32;
  localparam int VW      = 7 + 2 + 2 * NB_CNT;

  logic               clk = 1'b0;
  logic               rst;
  logic               run, step, halt, uses_rt, memrd, br, jmp;
  logic [NB_ADDR-1:0] rs, rt, exrt;
  logic               pc_en, if_id_en, flush, id_ex_en, bubble, ex_mem_en, mem_wb_en;
  logic [1:0]         state;
  logic [NB_CNT-1:0]  cyc, stl;
  logic [VW-1:0]      dut_vec;

  int checks   = 0;
  int failures = 0;

  // reference model: mode 0=idle 1=run 2=step 3=halted
  int               m_mode;
  logic [NB_CNT-1:0] m_cyc, m_stl;

  pipeline_hazard_ctrl #(.NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)) dut (
    .clk(clk), .rst(rst), .i_run(run), .i_step(step), .i_halt_wb(halt),
    .i_id_rs_addr(rs), .i_id_rt_addr(rt), .i_id_uses_rt(uses_rt),
    .i_ex_rt_addr(exrt), .i_ex_MemRead(memrd), .i_branch_taken(br), .i_jump(jmp),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(flush),
    .o_id_ex_en(id_ex_en), .o_id_ex_bubble(bubble), .o_ex_mem_en(ex_mem_en),
    .o_mem_wb_en(mem_wb_en), .o_state(state), .o_cycle_cnt(cyc), .o_stall_cnt(stl)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pc_en, if_id_en, flush, id_ex_en, bubble, ex_mem_en, mem_wb_en,
                    state, cyc, stl};

  function automatic bit m_luh();
    return memrd && (exrt != 0) && ((exrt == rs) || (uses_rt && (exrt == rt)));
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    bit adv = (m_mode == 1) || (m_mode == 2);
    bit l   = m_luh();
    bit go  = adv && !l;
    return {go, go, go && (br || jmp), adv, adv && l, adv, adv,
            2'(m_mode), m_cyc, m_stl};
  endfunction

  task automatic model_adv();
    if (m_mode == 1 || m_mode == 2) begin
      m_cyc = m_cyc + 1;
      if (m_luh()) m_stl = m_stl + 1;
    end
    case (m_mode)
      0:       m_mode = run ? 1 : (step ? 2 : 0);
      1:       m_mode = halt ? 3 : (run ? 1 : 0);
      2:       m_mode = halt ? 3 : 0;
      default: m_mode = 3;
    endcase
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_cyc  = '0;
    m_stl  = '0;
  endtask

  task automatic clear_inputs();
    run = 0; step = 0; halt = 0; uses_rt = 0; memrd = 0; br = 0; jmp = 0;
    rs = '0; rt = '0; exrt = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", dut_vec, exp_vec());
    end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_step();
    for (int i = 0; i < 3; i++) begin
      step = (i < 2);
      @(negedge clk);
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL step_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      checks++;
      model_adv();
      @(posedge clk); #1;
    end
    if (cyc !== 32'd1 || state !== 2'd0) begin
      failures++;
      $display("FAIL step_single_advance: cycle_cnt=%0d state=%0d expected 1 and 0", cyc, state);
    end
    checks++;
  endtask

  task automatic test_load_use();
    // first entry cycle moves IDLE->RUN, then stall, then $zero destination
    for (int i = 0; i < 3; i++) begin
      run = 1; memrd = (i > 0); rs = 5'd8; exrt = (i == 2) ? 5'd0 : 5'd8;
      @(negedge clk);
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL load_use%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      checks++;
      model_adv();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_beats_flush();
    for (int i = 0; i < 2; i++) begin
      run = 1; br = 1; memrd = (i == 0); exrt = 5'd9; rs = 5'd9;
      @(negedge clk);
      if (dut_vec !== exp_vec() || flush !== (i == 1) || bubble !== (i == 0)) begin
        failures++;
        $display("FAIL stall_beats_flush%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      checks++;
      model_adv();
      @(posedge clk); #1;
    end
    br = 0;
  endtask

  task automatic test_uses_rt_jump();
    for (int i = 0; i < 2; i++) begin
      run = 1; uses_rt = 0; memrd = 1; exrt = 5'd5; rt = 5'd5; rs = 5'd1; jmp = (i == 1);
      @(negedge clk);
      if (dut_vec !== exp_vec() || bubble !== 1'b0) begin
        failures++;
        $display("FAIL uses_rt_jump%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      checks++;
      model_adv();
      @(posedge clk); #1;
    end
    clear_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      run     = ($urandom_range(0, 9) != 0);
      step    = $urandom_range(0, 1);
      uses_rt = $urandom_range(0, 1);
      memrd   = $urandom_range(0, 1);
      br      = ($urandom_range(0, 3) == 0);
      jmp     = ($urandom_range(0, 5) == 0);
      rs      = 5'($urandom_range(0, 3));
      rt      = 5'($urandom_range(0, 3));
      exrt    = 5'($urandom_range(0, 3));
      @(negedge clk);
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      checks++;
      model_adv();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    run = 1;
    @(posedge clk); #1;
    model_adv();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    if (dut_vec !== exp_vec()) begin
      failures++;
      $display("FAIL async_reset: got %h expected %h", dut_vec, exp_vec());
    end
    checks++;
    run = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_halt();
    clear_inputs();
    for (int i = 0; i < 8; i++) begin
      run  = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      step = (i >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      halt = (i == 1);
      @(negedge clk);
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL halt%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      checks++;
      model_adv();
      @(posedge clk); #1;
    end
    if (state !== 2'd3 || pc_en !== 1'b0 || mem_wb_en !== 1'b0) begin
      failures++;
      $display("FAIL halt_terminal: state=%0d pc_en=%b mem_wb_en=%b expected 3 0 0",
               state, pc_en, mem_wb_en);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_step();
    test_load_use();
    test_stall_beats_flush();
    test_uses_rt_jump();
    test_random();
    test_async_reset();
    test_halt();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
